// File: rtl/dma_intr_coalesce.sv
// Coalesces DMA block-completion pulses into one level interrupt request, raised on a count
// threshold or an idle timeout and retired by the controller's acknowledge.
module dma_intr_coalesce #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH          = 8,
  parameter int unsigned TIMER_WIDTH        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_write,
  input  logic [1:0]                    cfg_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] cfg_wdata,
  output logic [C_M_AXI_DATA_WIDTH-1:0] cfg_rdata,
  input  logic                          blk_done,
  output logic                          intr_req,
  input  logic                          intr_ack
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StReq   = 2'd2,
    StDrop  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   pending_q, pending_d;
  logic [CNT_WIDTH-1:0]   serviced_q, serviced_d;
  logic [CNT_WIDTH-1:0]   thresh_q, thresh_d;
  logic [TIMER_WIDTH-1:0] timeout_q, timeout_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   ack_d_q;
  logic                   intr_req_q, intr_req_d;

  logic                   ack_rise;
  logic [CNT_WIDTH-1:0]   thresh_eff;
  logic                   at_thresh;
  logic                   timed_out;

  assign ack_rise   = intr_ack & ~ack_d_q;
  assign thresh_eff = (thresh_q == '0) ? CNT_WIDTH'(1) : thresh_q;
  assign at_thresh  = (pending_d >= thresh_eff);
  assign timed_out  = (timeout_q != '0) && (timer_q == timeout_q - TIMER_WIDTH'(1));
  assign intr_req   = intr_req_q;

  always_comb begin
    thresh_d  = thresh_q;
    timeout_d = timeout_q;
    if (cfg_write) begin
      unique case (cfg_addr)
        2'd0:    thresh_d  = cfg_wdata[CNT_WIDTH-1:0];
        2'd1:    timeout_d = cfg_wdata[TIMER_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // An ack edge hands the count to SERVICED; a completion in that same cycle starts the next batch.
  always_comb begin
    pending_d  = pending_q;
    serviced_d = serviced_q;
    if (ack_rise) begin
      serviced_d = pending_q;
      pending_d  = blk_done ? CNT_WIDTH'(1) : '0;
    end else if (blk_done && (pending_q != '1)) begin
      pending_d = pending_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (pending_d != '0) begin
          if (at_thresh) begin
            state_d = StReq;
          end else begin
            state_d = StAccum;
            timer_d = '0;
          end
        end
      end
      StAccum: begin
        timer_d = timer_q + TIMER_WIDTH'(1);
        if (at_thresh || timed_out) state_d = StReq;
      end
      StReq: begin
        if (ack_rise) state_d = StDrop;
      end
      StDrop: begin
        if (!intr_ack) begin
          if (pending_d == '0) begin
            state_d = StIdle;
          end else if (at_thresh) begin
            state_d = StReq;
          end else begin
            state_d = StAccum;
            timer_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    intr_req_d = (state_d == StReq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      serviced_q <= '0;
      thresh_q   <= CNT_WIDTH'(1);
      timeout_q  <= '0;
      timer_q    <= '0;
      ack_d_q    <= 1'b0;
      intr_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      serviced_q <= serviced_d;
      thresh_q   <= thresh_d;
      timeout_q  <= timeout_d;
      timer_q    <= timer_d;
      ack_d_q    <= intr_ack;
      intr_req_q <= intr_req_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0: cfg_rdata[CNT_WIDTH-1:0]   = thresh_q;
      2'd1: cfg_rdata[TIMER_WIDTH-1:0] = timeout_q;
      2'd2: cfg_rdata[CNT_WIDTH+1:0]   = {pending_q, state_q};
      2'd3: cfg_rdata[CNT_WIDTH-1:0]   = serviced_q;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_intr_coalesce.sv
// Directed bench for dma_intr_coalesce: expected values are queued when stimulus is driven
// and popped against DUT outputs.
module tb_dma_intr_coalesce;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_write;
  logic [1:0]    cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic [DW-1:0] cfg_rdata;
  logic          blk_done;
  logic          intr_req;
  logic          intr_ack;

  dma_intr_coalesce #(
    .C_M_AXI_DATA_WIDTH(DW),
    .CNT_WIDTH         (CW),
    .TIMER_WIDTH       (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_write(cfg_write),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .blk_done (blk_done),
    .intr_req (intr_req),
    .intr_ack (intr_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("FAIL sb_empty observed=%0h expected=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        tests_failed++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_write = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_write = 1'b0;
  endtask

  task automatic pulse();
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
  endtask

  task automatic ack();
    intr_ack = 1'b1;
    tick();
    intr_ack = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          cnt;
    int          cyc;

    rst = 1'b1; cfg_write = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    blk_done = 1'b0; intr_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    push("rst_intr_req", 0);  check(32'(intr_req));
    push("rst_thresh", 1);    rd(2'd0, d); check(d);
    push("rst_timeout", 0);   rd(2'd1, d); check(d);
    push("rst_status", 0);    rd(2'd2, d); check(d);
    push("rst_serviced", 0);  rd(2'd3, d); check(d);

    // 1: THRESH=1, single pulse, one-cycle request latency and ack release
    repeat (3) tick();
    blk_done = 1'b1;
    push("t1_req_pre", 0);    check(32'(intr_req));
    tick();
    blk_done = 1'b0;
    push("t1_req_set", 1);    check(32'(intr_req));
    tick(); tick();
    push("t1_req_hold", 1);   check(32'(intr_req));
    intr_ack = 1'b1;
    tick();
    push("t1_req_clr", 0);    check(32'(intr_req));
    push("t1_drop", 3);       rd(2'd2, d); check(d);
    intr_ack = 1'b0;
    tick();
    push("t1_idle", 0);       rd(2'd2, d); check(d);
    push("t1_serviced", 1);   rd(2'd3, d); check(d);

    // 2: THRESH=4, no timeout: three pulses never fire
    wr(2'd0, 4); wr(2'd1, 0);
    wr(2'd2, 32'hFF);  // read-only, must be ignored
    repeat (3) pulse();
    push("t2_status", {3'b0, 8'd3, 2'd1}); rd(2'd2, d); check(d);
    cnt = 0;
    repeat (1000) begin tick(); if (intr_req) cnt++; end
    push("t2_no_req", 0);     check(32'(cnt));
    pulse();
    push("t2_req", 1);        check(32'(intr_req));
    ack();
    push("t2_serviced", 4);   rd(2'd3, d); check(d);
    push("t2_idle", 0);       rd(2'd2, d); check(d);

    // 3: THRESH=8, TIMEOUT=20, first pulse at cycle 0 -> request at cycle 21
    wr(2'd0, 8); wr(2'd1, 20);
    pulse(); cyc = 1;
    repeat (4) begin tick(); cyc++; end
    pulse(); cyc++;
    while (!intr_req && cyc < 60) begin tick(); cyc++; end
    push("t3_latency", 21);   check(32'(cyc));
    ack();
    push("t3_serviced", 2);   rd(2'd3, d); check(d);

    // 4: completion coincident with ack edge, pending=5, THRESH=4
    wr(2'd1, 0); wr(2'd0, 4);
    repeat (5) pulse();
    push("t4_status_req", {3'b0, 8'd5, 2'd2}); rd(2'd2, d); check(d);
    intr_ack = 1'b1; blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    push("t4_req_clr", 0);    check(32'(intr_req));
    push("t4_serviced", 5);   rd(2'd3, d); check(d);
    push("t4_status_drop", {3'b0, 8'd1, 2'd3}); rd(2'd2, d); check(d);
    intr_ack = 1'b0;
    tick();
    push("t4_status_accum", {3'b0, 8'd1, 2'd1}); rd(2'd2, d); check(d);
    repeat (3) pulse();
    push("t4_req_again", 1);  check(32'(intr_req));
    ack();

    // 5: THRESH=0 acts as 1; 300 pulses with ack withheld saturate at 255
    wr(2'd0, 0);
    push("t5_thresh_rd", 0);  rd(2'd0, d); check(d);
    blk_done = 1'b1;
    repeat (300) tick();
    blk_done = 1'b0;
    push("t5_req", 1);        check(32'(intr_req));
    push("t5_status", {3'b0, 8'd255, 2'd2}); rd(2'd2, d); check(d);
    ack();
    push("t5_serviced", 255); rd(2'd3, d); check(d);
    push("t5_idle", 0);       rd(2'd2, d); check(d);

    // 6: reset while requesting with pending=3
    wr(2'd0, 3); wr(2'd1, 9);
    repeat (3) pulse();
    push("t6_req", 1);        check(32'(intr_req));
    push("t6_status_pre", {3'b0, 8'd3, 2'd2}); rd(2'd2, d); check(d);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push("t6_req_clr", 0);    check(32'(intr_req));
    push("t6_status", 0);     rd(2'd2, d); check(d);
    push("t6_thresh", 1);     rd(2'd0, d); check(d);
    push("t6_timeout", 0);    rd(2'd1, d); check(d);
    push("t6_serviced", 0);   rd(2'd3, d); check(d);

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
